// File: rtl/mips32_state_dump.sv
// mips32_state_dump
//
// Post-run readback engine for the pipelined MIPS32 core. When the core
// raises halted, this block walks the register file and then a window of
// data memory. It emits one word at a time on a valid/ready stream, and
// tags each word with its source and index. A host or UART bridge can then
// check program results without hierarchical peeks into the core.
//
// State table:
//   state   | meaning
//   IDLE    | waiting for a registered rising edge of halted
//   REG_RD  | reg_addr presents the current register; capture it at the edge
//   REG_OUT | register word offered on the stream; wait for acceptance
//   MEM_RD  | mem_addr presents the current word; capture it at the edge
//   MEM_OUT | memory word offered on the stream; wait for acceptance
//   FIN     | pulse done once, then wait for halted=0 before re-arming
//
// Ports:
//   clk1        in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   halted      in   core HALTED flag (level)
//   reg_addr    out  register-file read address
//   reg_rdata   in   register-file read data, combinational from reg_addr
//   mem_addr    out  memory read word address
//   mem_rdata   in   memory read data, combinational from mem_addr
//   dump_valid  out  output word valid
//   dump_ready  in   sink accepts word
//   dump_data   out  word value
//   dump_src    out  0 = register, 1 = memory
//   dump_index  out  register number or memory address
//   dump_last   out  final word of the dump (qualified by dump_valid)
//   busy        out  dump in progress
//   done        out  one-cycle pulse after the final word is accepted
//
// Parameters:
//   NUM_REGS   registers dumped, R0..R(NUM_REGS-1), 0..32
//   MEM_BASE   first memory word address dumped
//   MEM_WORDS  memory words dumped, 0..1023
//   ADDR_W     memory word-address width

module mips32_state_dump #(
  parameter int NUM_REGS  = 6,
  parameter int MEM_BASE  = 0,
  parameter int MEM_WORDS = 8,
  parameter int ADDR_W    = 10
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              halted,
  output logic [4:0]        reg_addr,
  input  logic [31:0]       reg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [31:0]       dump_data,
  output logic              dump_src,
  output logic [ADDR_W-1:0] dump_index,
  output logic              dump_last,
  output logic              busy,
  output logic              done
);

  localparam bit               HAS_REGS   = (NUM_REGS > 0);
  localparam bit               HAS_MEM    = (MEM_WORDS > 0);
  localparam logic [4:0]       REG_LAST   = HAS_REGS ? 5'(NUM_REGS - 1) : 5'd0;
  localparam logic [ADDR_W-1:0] MEM_BASE_A = ADDR_W'(MEM_BASE);
  localparam logic [10:0]      MEM_CNT    = 11'(MEM_WORDS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REG_RD  = 3'd1,
    REG_OUT = 3'd2,
    MEM_RD  = 3'd3,
    MEM_OUT = 3'd4,
    FIN     = 3'd5
  } state_t;

  state_t      state;
  state_t      state_nxt;
  state_t      first_state;
  state_t      after_regs;

  // halted_q resets to 1 so that a halted level already high when reset
  // is released does not look like a fresh edge; a new dump then needs
  // halted to be seen low first.
  logic        halted_q;
  logic [10:0] mem_left;   // memory words still to be captured, counts down
  logic        start;
  logic        abort;
  logic        reg_is_last;
  logic        mem_is_last;

  assign start       = halted & ~halted_q;
  // busy is high exactly while a dump is in flight, including the FIN
  // entry cycle, so it also qualifies the abort.
  assign abort       = busy & ~halted;
  assign reg_is_last = (reg_addr == REG_LAST);
  assign mem_is_last = (mem_left == 11'd1);

  always_comb begin
    first_state = FIN;
    if (HAS_REGS) begin
      first_state = REG_RD;
    end else if (HAS_MEM) begin
      first_state = MEM_RD;
    end
  end

  always_comb begin
    after_regs = FIN;
    if (HAS_MEM) begin
      after_regs = MEM_RD;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nxt = first_state;
          end
        end
        REG_RD: begin
          state_nxt = REG_OUT;
        end
        REG_OUT: begin
          if (dump_ready) begin
            state_nxt = reg_is_last ? after_regs : REG_RD;
          end
        end
        MEM_RD: begin
          state_nxt = MEM_OUT;
        end
        MEM_OUT: begin
          if (dump_ready) begin
            state_nxt = mem_is_last ? FIN : MEM_RD;
          end
        end
        FIN: begin
          if (!halted) begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      halted_q   <= 1'b1;
      reg_addr   <= '0;
      mem_addr   <= MEM_BASE_A;
      mem_left   <= '0;
      dump_valid <= 1'b0;
      dump_data  <= '0;
      dump_src   <= 1'b0;
      dump_index <= '0;
      dump_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      halted_q <= halted;
      done     <= 1'b0;
      if (abort) begin
        // The only case where a presented word is withdrawn.
        dump_valid <= 1'b0;
        dump_last  <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              busy     <= 1'b1;
              reg_addr <= '0;
              mem_addr <= MEM_BASE_A;
              mem_left <= MEM_CNT;
            end
          end
          REG_RD: begin
            dump_data  <= reg_rdata;
            dump_src   <= 1'b0;
            dump_index <= ADDR_W'(reg_addr);
            dump_valid <= 1'b1;
            dump_last  <= reg_is_last & ~HAS_MEM;
          end
          REG_OUT: begin
            if (dump_ready) begin
              dump_valid <= 1'b0;
              dump_last  <= 1'b0;
              reg_addr   <= reg_addr + 5'd1;
            end
          end
          MEM_RD: begin
            dump_data  <= mem_rdata;
            dump_src   <= 1'b1;
            dump_index <= mem_addr;
            dump_valid <= 1'b1;
            dump_last  <= mem_is_last;
          end
          MEM_OUT: begin
            if (dump_ready) begin
              dump_valid <= 1'b0;
              dump_last  <= 1'b0;
              // Natural ADDR_W-bit overflow gives the modulo wrap.
              mem_addr   <= mem_addr + ADDR_W'(1);
              mem_left   <= mem_left - 11'd1;
            end
          end
          FIN: begin
            // busy still high means this is the entry cycle.
            if (busy) begin
              done <= 1'b1;
              busy <= 1'b0;
            end
          end
          default: begin
            busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mips32_state_dump.sv
module tb_mips32_state_dump;

  typedef struct {
    logic       src;
    logic [9:0] index;
    logic [31:0] data;
    logic       last;
  } word_t;

  logic clk1 = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk1 = ~clk1;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  // ---------------- main instance (defaults) ----------------
  logic [31:0] regs [32];
  logic [31:0] mem  [1024];
  logic        m_halted = 1'b0;
  logic        m_ready  = 1'b0;
  logic [4:0]  m_reg_addr;
  logic [31:0] m_reg_rdata;
  logic [9:0]  m_mem_addr;
  logic [31:0] m_mem_rdata;
  logic        m_valid, m_src, m_last, m_busy, m_done;
  logic [31:0] m_data;
  logic [9:0]  m_index;

  assign m_reg_rdata = regs[m_reg_addr];
  assign m_mem_rdata = mem[m_mem_addr];

  mips32_state_dump u_main (
    .clk1(clk1), .rst_n(rst_n), .halted(m_halted),
    .reg_addr(m_reg_addr), .reg_rdata(m_reg_rdata),
    .mem_addr(m_mem_addr), .mem_rdata(m_mem_rdata),
    .dump_valid(m_valid), .dump_ready(m_ready), .dump_data(m_data),
    .dump_src(m_src), .dump_index(m_index), .dump_last(m_last),
    .busy(m_busy), .done(m_done)
  );

  // ---------------- zero-window instance ----------------
  logic        z_halted = 1'b0;
  logic [4:0]  z_reg_addr;
  logic [9:0]  z_mem_addr;
  logic        z_valid, z_src, z_last, z_busy, z_done;
  logic [31:0] z_data;
  logic [9:0]  z_index;
  int          z_valid_seen = 0;

  mips32_state_dump #(.NUM_REGS(0), .MEM_WORDS(0)) u_zero (
    .clk1(clk1), .rst_n(rst_n), .halted(z_halted),
    .reg_addr(z_reg_addr), .reg_rdata(32'h1111_1111),
    .mem_addr(z_mem_addr), .mem_rdata(32'h2222_2222),
    .dump_valid(z_valid), .dump_ready(1'b1), .dump_data(z_data),
    .dump_src(z_src), .dump_index(z_index), .dump_last(z_last),
    .busy(z_busy), .done(z_done)
  );

  // ---------------- wrap instance ----------------
  logic        w_halted = 1'b0;
  logic [4:0]  w_reg_addr;
  logic [3:0]  w_mem_addr;
  logic [31:0] w_mem_rdata;
  logic        w_valid, w_src, w_last, w_busy, w_done;
  logic [31:0] w_data;
  logic [3:0]  w_index;
  word_t       w_seen [$];
  int          w_done_cnt = 0;

  assign w_mem_rdata = 32'hC0DE_0000 | {28'd0, w_mem_addr};

  mips32_state_dump #(.NUM_REGS(0), .MEM_BASE(14), .MEM_WORDS(4), .ADDR_W(4)) u_wrap (
    .clk1(clk1), .rst_n(rst_n), .halted(w_halted),
    .reg_addr(w_reg_addr), .reg_rdata(32'h3333_3333),
    .mem_addr(w_mem_addr), .mem_rdata(w_mem_rdata),
    .dump_valid(w_valid), .dump_ready(1'b1), .dump_data(w_data),
    .dump_src(w_src), .dump_index(w_index), .dump_last(w_last),
    .busy(w_busy), .done(w_done)
  );

  // ---------------- model and compare process for main ----------------
  word_t exp_q [$];
  bit    mon_en = 1'b0;
  int    acc_cnt = 0;
  int    done_cnt = 0;
  bit    stalled_prev = 1'b0;
  logic [31:0] held_data;
  logic [9:0]  held_index;
  logic        held_src;

  // Expected stream for a complete dump: registers first, then the memory
  // window; only the very last word of the whole dump carries last.
  task automatic build_main();
    exp_q.delete();
    for (int k = 0; k < 6; k++) exp_q.push_back('{1'b0, 10'(k), regs[k], 1'b0});
    for (int j = 0; j < 8; j++) exp_q.push_back('{1'b1, 10'(j), mem[j], (j == 7)});
  endtask

  always @(negedge clk1) begin
    if (mon_en) begin
      if (m_valid) begin
        chk("busy_with_valid", {31'd0, m_busy}, 32'd1);
        if (stalled_prev) begin
          chk("stall_hold_data", m_data, held_data);
          chk("stall_hold_index", {22'd0, m_index}, {22'd0, held_index});
          chk("stall_hold_src", {31'd0, m_src}, {31'd0, held_src});
        end
        if (exp_q.size() == 0) begin
          chk("extra_word", {22'd0, m_index}, 32'hFFFF_FFFF);
        end else begin
          chk("word_data", m_data, exp_q[0].data);
          chk("word_src", {31'd0, m_src}, {31'd0, exp_q[0].src});
          chk("word_index", {22'd0, m_index}, {22'd0, exp_q[0].index});
          chk("word_last", {31'd0, m_last}, {31'd0, exp_q[0].last});
          if (m_ready) begin
            void'(exp_q.pop_front());
            acc_cnt++;
          end
        end
      end
      if (m_done) begin
        done_cnt++;
        chk("done_pending_words", 32'(exp_q.size()), 32'd0);
        chk("busy_at_done", {31'd0, m_busy}, 32'd0);
      end
      stalled_prev = m_valid && !m_ready;
      held_data    = m_data;
      held_index   = m_index;
      held_src     = m_src;
    end
  end

  always @(negedge clk1) begin
    if (z_valid) z_valid_seen++;
    if (w_valid) begin
      w_seen.push_back('{w_src, {6'd0, w_index}, w_data, w_last});
    end
    if (w_done) w_done_cnt++;
  end

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic wait_done(input int d0, input int budget, input string name);
    int n;
    n = 0;
    while (done_cnt <= d0 && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt <= d0) chk(name, 32'd0, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int n;
    for (int i = 0; i < 32; i++) regs[i] = 32'(i);
    for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
    mem[0] = 32'h2801000a;
    mem[1] = 32'h28020014;
    mem[2] = 32'h28030019;
    mem[3] = 32'h0ce77800;
    mem[4] = 32'h0ce77800;
    mem[5] = 32'h00222000;
    mem[6] = 32'h0ce77800;
    mem[7] = 32'h00832800;
    mem[8] = 32'hfc000000;
    mem[9] = 32'h00000000;

    // ---- reset state ----
    #12;
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_busy", {31'd0, m_busy}, 32'd0);
    chk("rst_done", {31'd0, m_done}, 32'd0);
    chk("rst_last", {31'd0, m_last}, 32'd0);
    chk("rst_data", m_data, 32'd0);
    chk("rst_index", {22'd0, m_index}, 32'd0);
    chk("rst_reg_addr", {27'd0, m_reg_addr}, 32'd0);
    chk("rst_mem_addr_wrap", {28'd0, w_mem_addr}, 32'd14);
    rst_n = 1'b1;
    tick();
    tick();

    // ---- model pins ----
    build_main();
    chk("pin_size", 32'(exp_q.size()), 32'd14);
    chk("pin_r5", exp_q[5].data, 32'd5);
    chk("pin_m0", exp_q[6].data, 32'h2801000a);
    chk("pin_m1", exp_q[7].data, 32'h28020014);
    chk("pin_m7", exp_q[13].data, 32'h00832800);
    chk("pin_last", {31'd0, exp_q[13].last}, 32'd1);

    // ---- basic dump, ready held high ----
    mon_en = 1'b1;
    acc_cnt = 0;
    m_ready = 1'b1;
    d0 = done_cnt;
    m_halted = 1'b1;
    tick();
    chk("lat_busy_1", {31'd0, m_busy}, 32'd1);
    chk("lat_valid_1", {31'd0, m_valid}, 32'd0);
    tick();
    chk("lat_valid_2", {31'd0, m_valid}, 32'd1);
    chk("lat_index_2", {22'd0, m_index}, 32'd0);
    wait_done(d0, 100, "basic_done_timeout");
    chk("basic_accepted", 32'(acc_cnt), 32'd14);
    chk("basic_done_cnt", 32'(done_cnt - d0), 32'd1);
    tick();
    chk("basic_done_width", {31'd0, m_done}, 32'd0);
    chk("basic_busy_after", {31'd0, m_busy}, 32'd0);
    tick();
    tick();
    chk("one_dump_per_halt", 32'(done_cnt - d0), 32'd1);
    m_halted = 1'b0;
    tick();
    tick();

    // ---- backpressure, ready 1 of 3 cycles ----
    build_main();
    acc_cnt = 0;
    m_ready = 1'b0;
    d0 = done_cnt;
    m_halted = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      m_ready = (i % 3 == 2);
      if (done_cnt > d0) break;
    end
    if (done_cnt <= d0) chk("bp_done_timeout", 32'd0, 32'd1);
    chk("bp_accepted", 32'(acc_cnt), 32'd14);
    m_ready = 1'b1;
    m_halted = 1'b0;
    tick();
    tick();

    // ---- abort after third word, then re-arm ----
    build_main();
    acc_cnt = 0;
    d0 = done_cnt;
    m_halted = 1'b1;
    n = 0;
    while (acc_cnt < 3 && n < 50) begin
      tick();
      n++;
    end
    chk("abort_reached_3", 32'(acc_cnt), 32'd3);
    m_halted = 1'b0;
    tick();
    chk("abort_valid", {31'd0, m_valid}, 32'd0);
    chk("abort_busy", {31'd0, m_busy}, 32'd0);
    exp_q.delete();
    tick();
    tick();
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    build_main();
    acc_cnt = 0;
    m_halted = 1'b1;
    wait_done(d0, 100, "rearm_done_timeout");
    chk("rearm_accepted", 32'(acc_cnt), 32'd14);
    m_halted = 1'b0;
    tick();
    tick();

    // ---- reset mid-dump ----
    build_main();
    acc_cnt = 0;
    m_halted = 1'b1;
    n = 0;
    while (!(m_valid && m_index == 10'd3) && n < 50) begin
      tick();
      n++;
    end
    m_ready = 1'b0;
    chk("rst_mid_pre_valid", {31'd0, m_valid}, 32'd1);
    mon_en = 1'b0;
    exp_q.delete();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_mid_busy", {31'd0, m_busy}, 32'd0);
    chk("rst_mid_data", m_data, 32'd0);
    chk("rst_mid_index", {22'd0, m_index}, 32'd0);
    chk("rst_mid_reg_addr", {27'd0, m_reg_addr}, 32'd0);
    #4;
    rst_n = 1'b1;
    stalled_prev = 1'b0;
    mon_en = 1'b1;
    m_ready = 1'b1;
    d0 = done_cnt;
    for (int i = 0; i < 6; i++) tick();
    chk("rst_no_restart_busy", {31'd0, m_busy}, 32'd0);
    chk("rst_no_restart_done", 32'(done_cnt - d0), 32'd0);
    m_halted = 1'b0;
    tick();
    tick();
    build_main();
    acc_cnt = 0;
    m_halted = 1'b1;
    wait_done(d0, 100, "rst_rearm_done_timeout");
    chk("rst_rearm_accepted", 32'(acc_cnt), 32'd14);
    m_halted = 1'b0;
    tick();

    // ---- zero windows ----
    z_halted = 1'b1;
    tick();
    chk("zero_busy_1", {31'd0, z_busy}, 32'd1);
    chk("zero_done_1", {31'd0, z_done}, 32'd0);
    tick();
    chk("zero_done_2", {31'd0, z_done}, 32'd1);
    chk("zero_busy_2", {31'd0, z_busy}, 32'd0);
    tick();
    chk("zero_done_3", {31'd0, z_done}, 32'd0);
    chk("zero_no_valid", 32'(z_valid_seen), 32'd0);
    z_halted = 1'b0;

    // ---- memory wrap ----
    w_halted = 1'b1;
    n = 0;
    while (w_done_cnt == 0 && n < 40) begin
      tick();
      n++;
    end
    chk("wrap_done", 32'(w_done_cnt), 32'd1);
    chk("wrap_count", 32'(w_seen.size()), 32'd4);
    if (w_seen.size() == 4) begin
      chk("wrap_idx0", {22'd0, w_seen[0].index}, 32'd14);
      chk("wrap_idx1", {22'd0, w_seen[1].index}, 32'd15);
      chk("wrap_idx2", {22'd0, w_seen[2].index}, 32'd0);
      chk("wrap_idx3", {22'd0, w_seen[3].index}, 32'd1);
      chk("wrap_data0", w_seen[0].data, 32'hC0DE_000E);
      chk("wrap_data3", w_seen[3].data, 32'hC0DE_0001);
      chk("wrap_src0", {31'd0, w_seen[0].src}, 32'd1);
      chk("wrap_last2", {31'd0, w_seen[2].last}, 32'd0);
      chk("wrap_last3", {31'd0, w_seen[3].last}, 32'd1);
    end
    w_halted = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
